// File: rtl/br_pkg.sv
// Shared definitions for the branch controller: condition codes, flag bit
// positions and the sequencer state encoding.
package br_pkg;

    localparam int unsigned COND_W = 3;
    localparam int unsigned FLAG_W = 6;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned FCNT_W = 3;

    localparam logic [COND_W-1:0] COND_LT = 3'b000;
    localparam logic [COND_W-1:0] COND_GT = 3'b001;
    localparam logic [COND_W-1:0] COND_LE = 3'b010;
    localparam logic [COND_W-1:0] COND_GE = 3'b011;
    localparam logic [COND_W-1:0] COND_EQ = 3'b100;
    localparam logic [COND_W-1:0] COND_NE = 3'b101;

    // Bit positions within the {NE,EQ,GE,LE,GT,LT} flag word
    localparam int unsigned FLAG_LT = 0;
    localparam int unsigned FLAG_GT = 1;
    localparam int unsigned FLAG_LE = 2;
    localparam int unsigned FLAG_GE = 3;
    localparam int unsigned FLAG_EQ = 4;
    localparam int unsigned FLAG_NE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Pure combinational branch condition evaluator; reserved codes never take.
module br_cond_eval
    import br_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            COND_LT: taken_c = flags[FLAG_LT];
            COND_GT: taken_c = flags[FLAG_GT];
            COND_LE: taken_c = flags[FLAG_LE];
            COND_GE: taken_c = flags[FLAG_GE];
            COND_EQ: taken_c = flags[FLAG_EQ];
            COND_NE: taken_c = flags[FLAG_NE];
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: flag register, in-flight compare scoreboard,
// decode stall while waiting on flags, registered redirect and timed flush.
module branch_ctrl
    import br_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned PEND_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_issue,
    input  logic              flags_wr,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              br_valid,
    input  logic              br_is_jump,
    input  logic [COND_W-1:0] br_cond,
    input  logic [PC_W-1:0]   br_target,
    output logic              br_stall,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush,
    output logic [FLAG_W-1:0] flags_q,
    output logic              err_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
    localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES);

    br_state_e         state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [FLAG_W-1:0] flags_d;
    logic              err_ovf_q, err_ovf_d;
    logic [COND_W-1:0] cond_q, cond_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              bypass_c;
    logic              ready_c;
    logic [FLAG_W-1:0] eval_flags_c;
    logic [COND_W-1:0] eval_cond_c;
    logic              taken_c;
    logic              take_c;
    logic [PC_W-1:0]   take_pc_c;

    // The last outstanding compare retiring this cycle can be consumed directly
    assign bypass_c     = (pend_q == PEND_ONE) && flags_wr && !cmp_issue;
    assign ready_c      = (pend_q == '0) || bypass_c;
    assign eval_flags_c = bypass_c ? flags_in : flags_q;
    assign eval_cond_c  = (state_q == WAIT) ? cond_q : br_cond;

    br_cond_eval u_cond_eval (
        .cond    (eval_cond_c),
        .flags   (eval_flags_c),
        .taken_c (taken_c)
    );

    // Flag register and compare scoreboard
    always_comb begin
        pend_d    = pend_q;
        err_ovf_d = err_ovf_q;
        flags_d   = flags_wr ? flags_in : flags_q;
        if (cmp_issue && !flags_wr) begin
            if (pend_q == PEND_MAX) begin
                err_ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (flags_wr && !cmp_issue && (pend_q != '0)) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Sequencer next-state, stall and redirect/flush generation
    always_comb begin
        state_d          = state_q;
        cond_d           = cond_q;
        target_d         = target_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        fcnt_d           = fcnt_q;
        br_stall         = 1'b0;
        take_c           = 1'b0;
        take_pc_c        = br_target;

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    if (br_is_jump) begin
                        take_c = 1'b1;
                    end else if (ready_c) begin
                        take_c = taken_c;
                    end else begin
                        cond_d   = br_cond;
                        target_d = br_target;
                        br_stall = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                br_stall  = 1'b1;
                take_pc_c = target_q;
                if (ready_c) begin
                    if (taken_c) begin
                        take_c = 1'b1;
                    end else begin
                        br_stall = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q <= FCNT_W'(1)) begin
                    flush_d = 1'b0;
                    fcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_c) begin
            state_d          = FLUSH;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = take_pc_c;
            flush_d          = 1'b1;
            fcnt_d           = FLUSH_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pend_q           <= '0;
            flags_q          <= '0;
            err_ovf_q        <= 1'b0;
            cond_q           <= '0;
            target_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            fcnt_q           <= '0;
        end else begin
            state_q          <= state_d;
            pend_q           <= pend_d;
            flags_q          <= flags_d;
            err_ovf_q        <= err_ovf_d;
            cond_q           <= cond_d;
            target_q         <= target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            fcnt_q           <= fcnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cycles, expected redirect
// targets queued at stimulus time and popped when redirect_valid fires.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmp_issue;
    logic        flags_wr;
    logic [5:0]  flags_in;
    logic        br_valid;
    logic        br_is_jump;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic        br_stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        flush;
    logic [5:0]  flags_q;
    logic        err_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    branch_ctrl #(.FLUSH_CYCLES(2), .PEND_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmp_issue      (cmp_issue),
        .flags_wr       (flags_wr),
        .flags_in       (flags_in),
        .br_valid       (br_valid),
        .br_is_jump     (br_is_jump),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .br_stall       (br_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flags_q        (flags_q),
        .err_ovf        (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ci, input logic fw, input logic [5:0] fi,
                         input logic bv, input logic bj, input logic [2:0] bc,
                         input logic [15:0] bt);
        cmp_issue  = ci;
        flags_wr   = fw;
        flags_in   = fi;
        br_valid   = bv;
        br_is_jump = bj;
        br_cond    = bc;
        br_target  = bt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        repeat (n) tick();
    endtask

    // Every redirect must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && redirect_valid) begin
            check("redirect_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("redirect_pc", 32'(redirect_pc), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        #2;
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_pc", 32'(redirect_pc), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_flags", 32'(flags_q), 32'd0);
        check("rst_ovf", 32'(err_ovf), 32'd0);
        check("rst_stall", 32'(br_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Unconditional jump; a second jump during flush is squashed
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 3'b000, 16'h0040);
        check("jump_stall", 32'(br_stall), 32'd0);
        exp_q.push_back(16'h0040);
        tick();
        check("jump_rv", 32'(redirect_valid), 32'd1);
        check("jump_flush1", 32'(flush), 32'd1);
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 3'b000, 16'h0099);
        check("flush_stall", 32'(br_stall), 32'd0);
        tick();
        check("jump_rv_pulse", 32'(redirect_valid), 32'd0);
        check("jump_flush2", 32'(flush), 32'd1);
        quiet(1);
        check("jump_flush_end", 32'(flush), 32'd0);

        // Resolved flags: NE not taken, EQ taken
        drive(1'b0, 1'b1, 6'b010000, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        check("flags_load", 32'(flags_q), 32'h10);
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'b101, 16'h0111);
        check("ne_stall", 32'(br_stall), 32'd0);
        tick();
        check("ne_rv", 32'(redirect_valid), 32'd0);
        check("ne_flush", 32'(flush), 32'd0);
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'b100, 16'h1234);
        exp_q.push_back(16'h1234);
        tick();
        check("eq_rv", 32'(redirect_valid), 32'd1);
        quiet(2);
        check("eq_flush_end", 32'(flush), 32'd0);

        // Stall on a pending compare, resolved taken in WAIT
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("cmp_stall", 32'(br_stall), 32'd0);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'b000, 16'h0200);
        check("blt_stall_c1", 32'(br_stall), 32'd1);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("blt_stall_c2", 32'(br_stall), 32'd1);
        tick();
        drive(1'b0, 1'b1, 6'b000001, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("blt_stall_c3", 32'(br_stall), 32'd1);
        exp_q.push_back(16'h0200);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("blt_rv_c4", 32'(redirect_valid), 32'd1);
        check("blt_flush_c4", 32'(flush), 32'd1);
        check("blt_stall_c4", 32'(br_stall), 32'd0);
        check("blt_flags", 32'(flags_q), 32'h01);
        tick();
        check("blt_flush_c5", 32'(flush), 32'd1);
        tick();
        check("blt_flush_c6", 32'(flush), 32'd0);

        // Bypass: last compare writes back in the branch cycle
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        drive(1'b0, 1'b1, 6'b001000, 1'b1, 1'b0, 3'b011, 16'h0300);
        check("byp_stall", 32'(br_stall), 32'd0);
        exp_q.push_back(16'h0300);
        tick();
        check("byp_rv", 32'(redirect_valid), 32'd1);
        check("byp_flags", 32'(flags_q), 32'h08);
        quiet(2);

        // WAIT resolved not taken: stall drops in the resolving cycle
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'b100, 16'h0400);
        check("nt_stall_wait", 32'(br_stall), 32'd1);
        tick();
        drive(1'b0, 1'b1, 6'b000001, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("nt_stall_drop", 32'(br_stall), 32'd0);
        tick();
        check("nt_rv", 32'(redirect_valid), 32'd0);
        check("nt_flush", 32'(flush), 32'd0);

        // Scoreboard saturation, simultaneous issue/writeback, overflow
        repeat (3) begin
            drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
            tick();
        end
        check("sb_three_ovf", 32'(err_ovf), 32'd0);
        drive(1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        check("sb_both_ovf", 32'(err_ovf), 32'd0);
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        check("sb_fourth_ovf", 32'(err_ovf), 32'd1);
        drive(1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 3'b000, 16'h0500);
        check("sb_pend3_stall", 32'(br_stall), 32'd1);
        tick();
        drive(1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("sb_pend2_stall", 32'(br_stall), 32'd1);
        tick();
        drive(1'b0, 1'b1, 6'b000001, 1'b0, 1'b0, 3'b000, 16'h0000);
        exp_q.push_back(16'h0500);
        tick();
        check("sb_drain_rv", 32'(redirect_valid), 32'd1);
        quiet(2);

        // Reserved condition codes never take, even with all flags set
        drive(1'b0, 1'b1, 6'h3f, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        for (int c = 6; c < 8; c++) begin
            drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'(c), 16'h0600);
            check("rsv_stall", 32'(br_stall), 32'd0);
            tick();
            check("rsv_rv", 32'(redirect_valid), 32'd0);
            check("rsv_flush", 32'(flush), 32'd0);
        end
        check("ovf_sticky", 32'(err_ovf), 32'd1);

        // Reset while in WAIT abandons the branch
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 3'b000, 16'h0700);
        tick();
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 3'b000, 16'h0000);
        check("wait_pre_rst_stall", 32'(br_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("wrst_stall", 32'(br_stall), 32'd0);
        check("wrst_ovf", 32'(err_ovf), 32'd0);
        check("wrst_flags", 32'(flags_q), 32'd0);
        check("wrst_pc", 32'(redirect_pc), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 6'b000001, 1'b0, 1'b0, 3'b000, 16'h0000);
        tick();
        check("wrst_after_rv", 32'(redirect_valid), 32'd0);
        quiet(3);
        check("wrst_after_flush", 32'(flush), 32'd0);

        // Reset while flushing
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 3'b000, 16'h0800);
        exp_q.push_back(16'h0800);
        tick();
        check("frst_pre_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        check("frst_flush", 32'(flush), 32'd0);
        check("frst_rv", 32'(redirect_valid), 32'd0);
        check("frst_pc", 32'(redirect_pc), 32'd0);
        rst_n = 1'b1;
        quiet(3);
        check("frst_after_flush", 32'(flush), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch/jump resolution for the 16-bit pipeline.
- Owns the architectural condition-flag register and a scoreboard of in-flight compares.
- Stalls decode while a conditional branch waits for its flags, then issues a registered PC redirect and a multi-cycle pipeline flush.
- Sits between decode (branch requests), execute/writeback (compare flags) and the fetch PC mux.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles flush stays high after a redirect (1..7).
- PEND_W, 2, width of the outstanding-compare counter; maximum outstanding compares is 2^PEND_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmp_issue  in  1  a compare instruction entered execute this cycle.
- flags_wr  in  1  compare result written back this cycle.
- flags_in  in  6  {NE,EQ,GE,LE,GT,LT}, valid when flags_wr.
- br_valid  in  1  a branch or jump is in decode.
- br_is_jump  in  1  unconditional jump qualifier for br_valid.
- br_cond  in  3  condition code: 000 LT, 001 GT, 010 LE, 011 GE, 100 EQ, 101 NE, 110/111 reserved (never taken).
- br_target  in  16  target PC.
- br_stall  out  1  hold decode; combinational.
- redirect_valid  out  1  registered one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  16  registered target.
- flush  out  1  squash younger stages.
- flags_q  out  6  current flag register.
- err_ovf  out  1  sticky scoreboard overflow.

Behaviour:
- Reset (async, rst_n=0): state IDLE, pending=0, flags_q=0, redirect_valid=0, redirect_pc=0, flush=0, flush counter 0, err_ovf=0. Reset mid-WAIT or mid-FLUSH abandons the branch; no redirect follows.
- Flag register: flags_q loads flags_in on every flags_wr, in any state.
- Scoreboard pending:
  - +1 on cmp_issue only; -1 on flags_wr only; unchanged when both or neither.
  - flags_wr with pending=0 leaves pending at 0; flags still load.
  - cmp_issue alone with pending at max: saturate and set err_ovf (cleared only by reset).
- Flags usable this cycle (ready): pending==0, or (pending==1 and flags_wr and !cmp_issue). In the bypass case, evaluate on flags_in, not flags_q.
- State IDLE:
  - br_valid & br_is_jump: decide taken, go FLUSH.
  - br_valid & conditional & ready: evaluate. If taken, go FLUSH. If not taken, stay IDLE with no stall.
  - br_valid & conditional & !ready: latch br_cond/br_target, set br_stall=1, go WAIT.
- State WAIT:
  - br_stall=1 regardless of br_valid.
  - Re-evaluate the latched cond each cycle the flags become ready. Taken goes to FLUSH; not taken goes to IDLE, and br_stall drops in that same cycle.
- Taken decision in cycle N:
  - Cycle N+1: redirect_valid=1, redirect_pc=target, flush=1.
  - flush stays high for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES), then the block returns to IDLE.
- State FLUSH: br_valid is ignored (the request is being squashed) and br_stall=0. Flags and the scoreboard keep updating.
- Throughput: back-to-back taken branches are separated by at least FLUSH_CYCLES+1 cycles.
- Arithmetic: pending is unsigned PEND_W bits; the flush counter is 3 bits and counts down to 1.

Decomposition:
- Shared package br_pkg: condition-code localparams (COND_LT..COND_NE), flag bit indices, state enum {IDLE, WAIT, FLUSH}.
- Sub-module br_cond_eval: pure combinational (cond[2:0], flags[5:0]) -> taken; reserved codes yield 0. It is also reusable by the existing decode-stage branch logic.

Test Plan:
- Reset then jump: br_valid=1, br_is_jump=1, target 16'h0040 at cycle 0. Expect redirect_valid=1 and redirect_pc=16'h0040 at cycle 1; flush=1 on cycles 1-2; br_stall=0 throughout.
- Resolved compare, not taken: flags_wr with flags_in EQ=1 only, then BEQ... use cond NE (101) with pending=0. Expect no redirect, no flush, br_stall=0.
- Stall on pending compare: cmp_issue at cycle 0, BLT (000) at cycle 1. Expect br_stall=1 at cycle 1. flags_wr with LT=1 at cycle 3: br_stall=1 through cycle 3, redirect at cycle 4, flush on cycles 4-5, br_stall=0 from cycle 4.
- Bypass: pending=1, branch GE (011) arrives in the same cycle as flags_wr with GE=1. Expect no stall and redirect next cycle; flags_q=flags_in afterwards.
- Scoreboard edges: three cmp_issue with PEND_W=2 gives pending=3, err_ovf=0. A fourth gives err_ovf=1 and pending=3. Simultaneous cmp_issue+flags_wr leaves pending unchanged. Reserved cond 110 with flags all-ones is never taken.
- Reset mid-operation: assert rst_n=0 while in WAIT and while flush=1. Expect all outputs 0 immediately (asynchronous) and no redirect after release.
